// File: rtl/dcm_clkgen_prog_ctrl.sv
// Run-time reprogramming controller for the DCM_CLKGEN.
// It shifts LoadD, LoadM and GO commands out over PROGEN/PROGDATA, then waits
// for PROGDONE together with LOCKED. If they do not arrive in time, it pulses
// the DCM reset. All outputs are registered from the next-state logic, so they
// follow the state register by one clock.
module dcm_clkgen_prog_ctrl #(
  parameter logic [7:0]  M_M1_DEFAULT   = 8'd95,
  parameter logic [7:0]  D_M1_DEFAULT   = 8'd124,
  parameter bit          AUTOLOAD       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned DCM_RST_CYCLES = 3
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_i,
  input  logic [7:0] mult_m1_i,
  input  logic [7:0] div_m1_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [1:0] err_code_o,
  output logic [7:0] cur_mult_m1_o,
  output logic [7:0] cur_div_m1_o,
  output logic       progen_o,
  output logic       progdata_o,
  input  logic       progdone_i,
  input  logic       locked_i,
  output logic       dcm_rst_o
);

  typedef enum logic [2:0] {
    IDLE, LOAD_D, GAP1, LOAD_M, GAP2, GO, WAIT_DONE, DCM_RST
  } state_t;

  state_t      state, state_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [31:0] tmr, tmr_n;
  logic [7:0]  lat_m, lat_m_n, lat_d, lat_d_n;
  logic        autoload, autoload_n;

  logic        busy_n, done_n, err_n, progen_n, progdata_n, dcm_rst_n;
  logic [1:0]  err_code_n;
  logic [7:0]  cur_m_n, cur_d_n;
  logic [7:0]  cand_m, cand_d;
  logic [2:0]  idx;

  // State, counters, latched pair and every output register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      tmr           <= '0;
      lat_m         <= M_M1_DEFAULT;
      lat_d         <= D_M1_DEFAULT;
      autoload      <= AUTOLOAD;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      err_code_o    <= '0;
      cur_mult_m1_o <= M_M1_DEFAULT;
      cur_div_m1_o  <= D_M1_DEFAULT;
      progen_o      <= 1'b0;
      progdata_o    <= 1'b0;
      dcm_rst_o     <= 1'b0;
    end else begin
      state         <= state_n;
      bit_cnt       <= bit_cnt_n;
      tmr           <= tmr_n;
      lat_m         <= lat_m_n;
      lat_d         <= lat_d_n;
      autoload      <= autoload_n;
      busy_o        <= busy_n;
      done_o        <= done_n;
      err_o         <= err_n;
      err_code_o    <= err_code_n;
      cur_mult_m1_o <= cur_m_n;
      cur_div_m1_o  <= cur_d_n;
      progen_o      <= progen_n;
      progdata_o    <= progdata_n;
      dcm_rst_o     <= dcm_rst_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    tmr_n      = tmr;
    lat_m_n    = lat_m;
    lat_d_n    = lat_d;
    autoload_n = autoload;
    busy_n     = busy_o;
    done_n     = 1'b0;
    err_n      = 1'b0;
    err_code_n = err_code_o;
    cur_m_n    = cur_mult_m1_o;
    cur_d_n    = cur_div_m1_o;
    progen_n   = 1'b0;
    progdata_n = 1'b0;
    dcm_rst_n  = 1'b0;
    cand_m     = autoload ? M_M1_DEFAULT : mult_m1_i;
    cand_d     = autoload ? D_M1_DEFAULT : div_m1_i;
    // Payload bits follow the two header bits, LSB first
    idx        = 3'(bit_cnt - 4'd2);

    unique case (state)
      IDLE: begin
        // A pending autoload takes priority over req_i in the same cycle
        if (autoload || req_i) begin
          autoload_n = 1'b0;
          lat_m_n    = cand_m;
          lat_d_n    = cand_d;
          if (cand_m == 8'd0) begin
            err_n      = 1'b1;
            err_code_n = 2'd1;
          end else begin
            busy_n     = 1'b1;
            err_code_n = 2'd0;
            bit_cnt_n  = '0;
            state_n    = LOAD_D;
          end
        end
      end
      LOAD_D: begin
        progen_n   = 1'b1;
        progdata_n = (bit_cnt == 4'd0) ? 1'b1 :
                     (bit_cnt == 4'd1) ? 1'b0 : lat_d[idx];
        if (bit_cnt == 4'd9) begin
          bit_cnt_n = '0;
          state_n   = GAP1;
        end else begin
          bit_cnt_n = bit_cnt + 4'd1;
        end
      end
      GAP1: begin
        if (bit_cnt == 4'd1) begin
          bit_cnt_n = '0;
          state_n   = LOAD_M;
        end else begin
          bit_cnt_n = bit_cnt + 4'd1;
        end
      end
      LOAD_M: begin
        progen_n   = 1'b1;
        progdata_n = (bit_cnt < 4'd2) ? 1'b1 : lat_m[idx];
        if (bit_cnt == 4'd9) begin
          bit_cnt_n = '0;
          state_n   = GAP2;
        end else begin
          bit_cnt_n = bit_cnt + 4'd1;
        end
      end
      GAP2: begin
        if (bit_cnt == 4'd1) begin
          bit_cnt_n = '0;
          state_n   = GO;
        end else begin
          bit_cnt_n = bit_cnt + 4'd1;
        end
      end
      GO: begin
        progen_n = 1'b1;
        tmr_n    = '0;
        state_n  = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Success is tested first, so it wins a tie with the timeout
        if (progdone_i && locked_i) begin
          cur_m_n = lat_m;
          cur_d_n = lat_d;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (tmr == TIMEOUT_CYCLES - 32'd1) begin
          // The reset pulse starts on this edge, so the DCM_RST state counts from 1
          err_n      = 1'b1;
          err_code_n = 2'd2;
          dcm_rst_n  = 1'b1;
          tmr_n      = 32'd1;
          state_n    = DCM_RST;
        end else begin
          tmr_n = tmr + 32'd1;
        end
      end
      DCM_RST: begin
        if (tmr < DCM_RST_CYCLES) begin
          dcm_rst_n = 1'b1;
          tmr_n     = tmr + 32'd1;
        end else begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcm_clkgen_prog_ctrl.sv
// Directed and randomized bench for dcm_clkgen_prog_ctrl.
// The reference model builds the expected PROGEN/PROGDATA waveform from the
// command format. It times success or timeout from the GO pulse.
module tb_dcm_clkgen_prog_ctrl;

  localparam int TO  = 100;
  localparam int DRC = 3;
  localparam logic [7:0] M_DEF = 8'd95;
  localparam logic [7:0] D_DEF = 8'd124;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [7:0] m_in = '0, d_in = '0;
  logic       progdone = 1'b0, locked = 1'b0;
  logic       busy_o, done_o, err_o, progen_o, progdata_o, dcm_rst_o;
  logic [1:0] err_code_o;
  logic [7:0] cur_mult_m1_o, cur_div_m1_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_cur_m = M_DEF;
  logic [7:0] exp_cur_d = D_DEF;

  dcm_clkgen_prog_ctrl #(
    .M_M1_DEFAULT(M_DEF),
    .D_M1_DEFAULT(D_DEF),
    .AUTOLOAD(1'b1),
    .TIMEOUT_CYCLES(TO),
    .DCM_RST_CYCLES(DRC)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .req_i(req),
    .mult_m1_i(m_in),
    .div_m1_i(d_in),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o),
    .err_code_o(err_code_o),
    .cur_mult_m1_o(cur_mult_m1_o),
    .cur_div_m1_o(cur_div_m1_o),
    .progen_o(progen_o),
    .progdata_o(progdata_o),
    .progdone_i(progdone),
    .locked_i(locked),
    .dcm_rst_o(dcm_rst_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},     32'(busy_o), 0);
    chk({tag, "_done"},     32'(done_o), 0);
    chk({tag, "_err"},      32'(err_o), 0);
    chk({tag, "_code"},     32'(err_code_o), 0);
    chk({tag, "_progen"},   32'(progen_o), 0);
    chk({tag, "_progdata"}, 32'(progdata_o), 0);
    chk({tag, "_dcmrst"},   32'(dcm_rst_o), 0);
    chk({tag, "_curm"},     32'(cur_mult_m1_o), 32'(M_DEF));
    chk({tag, "_curd"},     32'(cur_div_m1_o), 32'(D_DEF));
  endtask

  task automatic issue(input logic [7:0] m, input logic [7:0] d);
    m_in = m;
    d_in = d;
    req  = 1'b1;
    tick();
    req  = 1'b0;
  endtask

  // Expected 25-cycle PROGEN/PROGDATA waveform built from the command layout.
  // A request is optionally injected at index mid_req, and reset at index abort_at.
  task automatic program_seq(input logic [7:0] m, input logic [7:0] d,
                             input int mid_req, input int abort_at);
    int en [25];
    int dat[25];
    int w;
    for (int i = 0; i < 25; i++) begin
      if (i < 10) begin
        en[i]  = 1;
        dat[i] = (i == 0) ? 1 : (i == 1) ? 0 : ((int'(d) >> (i - 2)) & 1);
      end else if (i < 12) begin
        en[i] = 0; dat[i] = 0;
      end else if (i < 22) begin
        en[i]  = 1;
        dat[i] = (i - 12 < 2) ? 1 : ((int'(m) >> (i - 14)) & 1);
      end else if (i < 24) begin
        en[i] = 0; dat[i] = 0;
      end else begin
        en[i] = 1; dat[i] = 0;
      end
    end
    w = 0;
    while (progen_o !== 1'b1 && w < 30) begin
      tick();
      w++;
    end
    chk("progen_start", 32'(progen_o), 1);
    for (int i = 0; i < 25; i++) begin
      if (i == mid_req + 1) req = 1'b0;
      chk($sformatf("progen[%0d]", i),   32'(progen_o),   32'(en[i]));
      chk($sformatf("progdata[%0d]", i), 32'(progdata_o), 32'(dat[i]));
      chk($sformatf("busy_seq[%0d]", i), 32'(busy_o), 1);
      if (i == mid_req) begin
        m_in = 8'($urandom_range(1, 255));
        d_in = 8'($urandom_range(0, 255));
        req  = 1'b1;
      end
      if (i == abort_at) begin
        rst_n = 1'b0;
        tick();
        exp_cur_m = M_DEF;
        exp_cur_d = D_DEF;
        chk_reset_vals("midrst");
        return;
      end
      if (i < 24) tick();
    end
  endtask

  // DCM model: raises progdone/locked 'delay' cycles after the GO pulse (never if delay<0)
  task automatic wait_result(input logic [7:0] m, input logic [7:0] d, input int delay);
    bit success;
    int exp_t;
    int t;
    int n;
    success = (delay >= 1) && (delay + 1 <= TO);
    exp_t   = success ? delay + 1 : TO;
    t = 0;
    do begin
      tick();
      t++;
      progdone = (t == delay);
      locked   = (t == delay);
    end while (!(done_o === 1'b1 || err_o === 1'b1) && t < TO + 20);
    progdone = 1'b0;
    locked   = 1'b0;
    chk("event_time", 32'(t), 32'(exp_t));
    if (success) begin
      exp_cur_m = m;
      exp_cur_d = d;
      chk("done_pulse", 32'(done_o), 1);
      chk("no_err",     32'(err_o), 0);
      chk("busy_done",  32'(busy_o), 0);
      chk("code_ok",    32'(err_code_o), 0);
    end else begin
      chk("err_pulse",  32'(err_o), 1);
      chk("no_done",    32'(done_o), 0);
      chk("code_to",    32'(err_code_o), 2);
      chk("dcmrst_on",  32'(dcm_rst_o), 1);
      n = 0;
      while (dcm_rst_o === 1'b1 && n < 20) begin
        n++;
        tick();
      end
      chk("dcmrst_width", 32'(n), 32'(DRC));
      chk("busy_after_rst", 32'(busy_o), 0);
    end
    chk("cur_m", 32'(cur_mult_m1_o), 32'(exp_cur_m));
    chk("cur_d", 32'(cur_div_m1_o), 32'(exp_cur_d));
    tick();
    chk("done_1cyc", 32'(done_o), 0);
    chk("err_1cyc",  32'(err_o), 0);
  endtask

  task automatic full_req(input logic [7:0] m, input logic [7:0] d, input int delay);
    issue(m, d);
    chk("accept_busy", 32'(busy_o), 1);
    chk("accept_code", 32'(err_code_o), 0);
    program_seq(m, d, -5, -1);
    wait_result(m, d, delay);
  endtask

  initial begin
    logic [7:0] rm, rd;
    int cnt;

    // Reset, then the autoload of the default pair
    repeat (3) tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    program_seq(M_DEF, D_DEF, -5, -1);
    wait_result(M_DEF, D_DEF, 50);

    // M-1 of zero is rejected without touching the DCM
    issue(8'd0, 8'd4);
    chk("badm_err",  32'(err_o), 1);
    chk("badm_code", 32'(err_code_o), 1);
    chk("badm_busy", 32'(busy_o), 0);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (progen_o === 1'b1) cnt++;
      tick();
    end
    chk("badm_progen", 32'(cnt), 0);
    chk("badm_code_held", 32'(err_code_o), 1);
    chk("badm_curm", 32'(cur_mult_m1_o), 32'(exp_cur_m));
    chk("badm_curd", 32'(cur_div_m1_o), 32'(exp_cur_d));

    // Extreme pair
    full_req(8'hFF, 8'h00, int'($urandom_range(1, 98)));

    // No PROGDONE: timeout and DCM reset
    full_req(8'($urandom_range(1, 255)), 8'($urandom_range(0, 255)), -1);

    // Success on the very cycle the timeout would fire
    full_req(8'($urandom_range(1, 255)), 8'($urandom_range(0, 255)), TO - 1);

    // Random pairs and delays; delays past the window time out
    for (int k = 0; k < 5; k++) begin
      rm = 8'($urandom_range(1, 255));
      rd = 8'($urandom_range(0, 255));
      full_req(rm, rd, int'($urandom_range(1, 120)));
    end

    // A second request during LOAD_M is dropped and not queued
    rm = 8'($urandom_range(1, 255));
    rd = 8'($urandom_range(0, 255));
    issue(rm, rd);
    program_seq(rm, rd, 14, -1);
    wait_result(rm, rd, int'($urandom_range(1, 60)));
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (progen_o === 1'b1 || busy_o === 1'b1) cnt++;
      tick();
    end
    chk("no_queued_req", 32'(cnt), 0);

    // Reset while LOAD_D is shifting D-1 bit 5, with a competing req on release
    rm = 8'($urandom_range(1, 255));
    rd = 8'($urandom_range(0, 255));
    issue(rm, rd);
    program_seq(rm, rd, -5, 7);
    rst_n = 1'b1;
    m_in  = 8'h33;
    d_in  = 8'h44;
    req   = 1'b1;
    tick();
    req   = 1'b0;
    chk("reautoload_busy", 32'(busy_o), 1);
    program_seq(M_DEF, D_DEF, -5, -1);
    wait_result(M_DEF, D_DEF, 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
